// File: rtl/io_input_port_pkg.sv
// Shared constants and helpers for the memory-mapped input port:
// register word offsets inside the 16-byte window, the default window
// base, and the width of the per-bit debounce counter.
package io_pkg;

    // Word offsets (DataAdr[3:2]) of the four registers in the window.
    localparam logic [1:0] IO_SW_STATE  = 2'd0;  // byte offset 0x0
    localparam logic [1:0] IO_KEY_STATE = 2'd1;  // byte offset 0x4
    localparam logic [1:0] IO_KEY_EVENT = 2'd2;  // byte offset 0x8
    localparam logic [1:0] IO_IRQ_MASK  = 2'd3;  // byte offset 0xC

    // Default 16-byte-aligned base of the register window.
    localparam logic [31:0] IO_BASE_ADDR_DEFAULT = 32'hFFFF_0010;

    // Counter width able to hold DEBOUNCE_CYCLES-1; never narrower than 1 bit.
    function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/io_input_port_debounce_bit.sv
// One input bit: two-flop synchroniser, consecutive-sample debounce counter
// and the accepted (stable) level. 'rise' pulses on the same edge that the
// stable level goes 0->1, so the caller can latch an event at that edge.
module debounce_bit
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam int unsigned   CW       = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          mismatch_s;
    logic          accept_s;

    // Decide whether this edge accepts the synchronised level as the new stable value.
    always_comb begin
        mismatch_s = (sync2_r != stable_r);
        accept_s   = 1'b0;
        if (mismatch_s && (cnt_r == CNT_LAST)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Synchronise the raw level and count consecutive samples that disagree with the stable value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= CNT_ZERO;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (accept_s) begin
                stable_r <= sync2_r;
                cnt_r    <= CNT_ZERO;
            end else if (mismatch_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= CNT_ZERO;
            end
        end
    end

    assign stable = stable_r;
    assign rise   = accept_s & sync2_r;

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped input peripheral: debounced switches and push-buttons,
// sticky write-1-to-clear press flags, an interrupt mask and a registered
// level interrupt. Reads are combinational from registered state so a
// single-cycle CPU load sees the value as of the last clock edge.
module io_input_port
    import io_pkg::*;
#(
    parameter int unsigned N_SW            = 10,
    parameter int unsigned N_KEY           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] BASE_ADDR       = IO_BASE_ADDR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  SW,
    input  logic [N_KEY-1:0] KEY_n,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    input  logic             MemWrite,
    output logic [31:0]      ReadData,
    output logic             key_irq
);

    logic [N_SW-1:0]  sw_stable_s;
    logic [N_SW-1:0]  sw_rise_s;
    logic [N_KEY-1:0] key_stable_s;
    logic [N_KEY-1:0] key_rise_s;
    logic [N_KEY-1:0] key_event_r;
    logic [N_KEY-1:0] irq_mask_r;
    logic             key_irq_r;
    logic             in_window_s;
    logic [1:0]       offset_s;
    logic [N_KEY-1:0] w1c_s;
    logic             mask_we_s;
    logic [31:0]      read_s;
    logic             unused_s;

    // Switch debouncers; the rise pulse is not needed for switches.
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (SW[i]),
            .stable (sw_stable_s[i]),
            .rise   (sw_rise_s[i])
        );
    end

    // Key debouncers run on the inverted level so that reset state means "released".
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (~KEY_n[i]),
            .stable (key_stable_s[i]),
            .rise   (key_rise_s[i])
        );
    end

    assign unused_s = ^{DataAdr[1:0], WriteData[31:N_KEY], sw_rise_s};

    // Address decode and store strobes for the two writable registers.
    always_comb begin
        in_window_s = (DataAdr[31:4] == BASE_ADDR[31:4]);
        offset_s    = DataAdr[3:2];
        w1c_s       = {N_KEY{1'b0}};
        mask_we_s   = 1'b0;
        if (MemWrite && in_window_s) begin
            case (offset_s)
                IO_KEY_EVENT: w1c_s     = WriteData[N_KEY-1:0];
                IO_IRQ_MASK:  mask_we_s = 1'b1;
                default: begin
                    w1c_s     = {N_KEY{1'b0}};
                    mask_we_s = 1'b0;
                end
            endcase
        end else begin
            w1c_s     = {N_KEY{1'b0}};
            mask_we_s = 1'b0;
        end
    end

    // Sticky press flags (a new press beats a same-edge clear), mask register and interrupt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_event_r <= {N_KEY{1'b0}};
            irq_mask_r  <= {N_KEY{1'b0}};
            key_irq_r   <= 1'b0;
        end else begin
            key_event_r <= (key_event_r & ~w1c_s) | key_rise_s;
            if (mask_we_s) begin
                irq_mask_r <= WriteData[N_KEY-1:0];
            end else begin
                irq_mask_r <= irq_mask_r;
            end
            key_irq_r <= |(key_event_r & irq_mask_r);
        end
    end

    // Read mux; anything outside the window or in unused bits reads as zero.
    always_comb begin
        read_s = 32'h0000_0000;
        if (in_window_s) begin
            case (offset_s)
                IO_SW_STATE:  read_s[N_SW-1:0]  = sw_stable_s;
                IO_KEY_STATE: read_s[N_KEY-1:0] = key_stable_s;
                IO_KEY_EVENT: read_s[N_KEY-1:0] = key_event_r;
                IO_IRQ_MASK:  read_s[N_KEY-1:0] = irq_mask_r;
                default:      read_s            = 32'h0000_0000;
            endcase
        end else begin
            read_s = 32'h0000_0000;
        end
    end

    assign ReadData = read_s;
    assign key_irq  = key_irq_r;

endmodule

// File: tb/tb_io_input_port.sv
// Self-checking bench for io_input_port. A reference model keeps the
// history of raw input samples and accepts a new level once the last
// DB synchronised samples all disagree with the current accepted level.
module tb_io_input_port;

    localparam int          DB     = 4;
    localparam logic [31:0] BASE   = 32'hFFFF_0010;
    localparam logic [31:0] A_SW   = 32'hFFFF_0010;
    localparam logic [31:0] A_KEY  = 32'hFFFF_0014;
    localparam logic [31:0] A_EVT  = 32'hFFFF_0018;
    localparam logic [31:0] A_MASK = 32'hFFFF_001C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  SW;
    logic [3:0]  KEY_n;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        key_irq;

    int errors = 0;
    int checks = 0;

    // Model state: raw sample history ({pressed keys, switches}) and register contents.
    logic [13:0] hist [0:63];
    logic [13:0] m_stable;
    logic [3:0]  m_event;
    logic [3:0]  m_mask;
    logic        m_irq;
    int          edge_n = 0;

    io_input_port #(
        .N_SW(10), .N_KEY(4), .DEBOUNCE_CYCLES(DB), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .SW(SW), .KEY_n(KEY_n),
        .DataAdr(DataAdr), .WriteData(WriteData), .MemWrite(MemWrite),
        .ReadData(ReadData), .key_irq(key_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd0: r = {22'h0, m_stable[9:0]};
                2'd1: r = {28'h0, m_stable[13:10]};
                2'd2: r = {28'h0, m_event};
                default: r = {28'h0, m_mask};
            endcase
        end
        return r;
    endfunction

    // Advance one clock edge and update the model with the inputs present at that edge.
    task automatic tick();
        logic [13:0] nxt;
        logic [3:0]  rise;
        logic [3:0]  w1c;
        logic [3:0]  new_mask;
        bit          all_diff;
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            hist[(edge_n + 63) % 64] = 14'h0;
            hist[edge_n % 64]        = 14'h0;
            m_stable = 14'h0;
            m_event  = 4'h0;
            m_mask   = 4'h0;
            m_irq    = 1'b0;
        end else begin
            hist[edge_n % 64] = {~KEY_n, SW};
            nxt = m_stable;
            for (int b = 0; b < 14; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    if (hist[(edge_n + 64 - 2 - j) % 64][b] == m_stable[b]) all_diff = 1'b0;
                end
                if (all_diff) nxt[b] = ~m_stable[b];
            end
            rise     = nxt[13:10] & ~m_stable[13:10];
            w1c      = 4'h0;
            new_mask = m_mask;
            if (MemWrite && DataAdr[31:4] == BASE[31:4]) begin
                if (DataAdr[3:2] == 2'd2) w1c = WriteData[3:0];
                else if (DataAdr[3:2] == 2'd3) new_mask = WriteData[3:0];
            end
            m_irq    = |(m_event & m_mask);
            m_event  = (m_event & ~w1c) | rise;
            m_mask   = new_mask;
            m_stable = nxt;
        end
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        DataAdr   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [4];
        addrs = '{A_SW, A_KEY, A_EVT, A_MASK};
        rst_n = 1'b0; SW = 10'h0; KEY_n = 4'hF; MemWrite = 1'b0;
        DataAdr = 32'h0; WriteData = 32'h0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DataAdr = addrs[i];
            #1;
            checks++;
            if (ReadData !== 32'h0) $display("FAIL reset_read[%0h]: got=%h want=%h", addrs[i], ReadData, 32'h0);
            if (ReadData !== 32'h0) errors++;
        end
        checks++;
        if (key_irq !== 1'b0) begin
            $display("FAIL reset_irq: got=%b want=0", key_irq);
            errors++;
        end
    endtask

    task automatic test_sw_debounce();
        DataAdr = A_SW;
        SW = 10'h2A5;
        for (int c = 0; c <= 5; c++) begin
            tick();
            checks++;
            if (ReadData !== model_read(DataAdr)) begin
                $display("FAIL sw_model c=%0d: got=%h want=%h", c, ReadData, model_read(DataAdr));
                errors++;
            end
            if (c == 4) begin
                checks++;
                if (ReadData !== 32'h0) begin
                    $display("FAIL sw_k4: got=%h want=%h", ReadData, 32'h0);
                    errors++;
                end
            end
            if (c == 5) begin
                checks++;
                if (ReadData !== 32'h2A5) begin
                    $display("FAIL sw_k5: got=%h want=%h", ReadData, 32'h2A5);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_key_glitch();
        KEY_n = 4'b1101;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) KEY_n = 4'hF;
            tick();
            DataAdr = A_KEY; #1;
            checks++;
            if (ReadData !== 32'h0) begin
                $display("FAIL glitch_state c=%0d: got=%h want=%h", c, ReadData, 32'h0);
                errors++;
            end
            DataAdr = A_EVT; #1;
            checks++;
            if (ReadData !== 32'h0) begin
                $display("FAIL glitch_event c=%0d: got=%h want=%h", c, ReadData, 32'h0);
                errors++;
            end
        end
        KEY_n = 4'b1101;
        for (int c = 0; c < 6; c++) begin
            tick();
            DataAdr = A_KEY; #1;
            checks++;
            if (ReadData !== model_read(DataAdr)) begin
                $display("FAIL press_state c=%0d: got=%h want=%h", c, ReadData, model_read(DataAdr));
                errors++;
            end
            if (c == 5) begin
                checks++;
                if (ReadData !== 32'h2) begin
                    $display("FAIL press_state_k5: got=%h want=%h", ReadData, 32'h2);
                    errors++;
                end
            end
            DataAdr = A_EVT; #1;
            checks++;
            if (ReadData !== model_read(DataAdr)) begin
                $display("FAIL press_event c=%0d: got=%h want=%h", c, ReadData, model_read(DataAdr));
                errors++;
            end
            if (c == 5) begin
                checks++;
                if (ReadData !== 32'h2) begin
                    $display("FAIL press_event_k5: got=%h want=%h", ReadData, 32'h2);
                    errors++;
                end
            end
        end
        KEY_n = 4'hF;
        for (int c = 0; c < 8; c++) begin
            tick();
            DataAdr = A_EVT; #1;
            checks++;
            if (ReadData !== 32'h2) begin
                $display("FAIL release_event c=%0d: got=%h want=%h", c, ReadData, 32'h2);
                errors++;
            end
        end
    endtask

    task automatic test_irq();
        store(A_MASK, 32'h2);
        checks++;
        if (key_irq !== m_irq) begin
            $display("FAIL irq_mask_edge: got=%b want=%b", key_irq, m_irq);
            errors++;
        end
        tick();
        checks++;
        if (key_irq !== 1'b1) begin
            $display("FAIL irq_assert: got=%b want=1", key_irq);
            errors++;
        end
        store(A_EVT, 32'h2);
        DataAdr = A_EVT; #1;
        checks++;
        if (ReadData !== 32'h0) begin
            $display("FAIL irq_w1c_event: got=%h want=%h", ReadData, 32'h0);
            errors++;
        end
        checks++;
        if (key_irq !== m_irq) begin
            $display("FAIL irq_w1c_edge: got=%b want=%b", key_irq, m_irq);
            errors++;
        end
        tick();
        checks++;
        if (key_irq !== 1'b0) begin
            $display("FAIL irq_deassert: got=%b want=0", key_irq);
            errors++;
        end
    endtask

    task automatic test_w1c_collision();
        KEY_n = 4'b1110;
        DataAdr = A_EVT;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (ReadData !== model_read(DataAdr)) begin
                $display("FAIL coll_pre c=%0d: got=%h want=%h", c, ReadData, model_read(DataAdr));
                errors++;
            end
        end
        store(A_EVT, 32'hF);
        DataAdr = A_EVT; #1;
        checks++;
        if (ReadData !== 32'h1) begin
            $display("FAIL coll_set_wins: got=%h want=%h", ReadData, 32'h1);
            errors++;
        end
        KEY_n = 4'hF;
        store(A_EVT, 32'h1);
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_reset_mid();
        store(A_MASK, 32'h5);
        KEY_n = 4'b1011;
        for (int c = 0; c < 3; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        KEY_n = 4'hF;
        for (int c = 0; c < 8; c++) begin
            tick();
            DataAdr = A_EVT; #1;
            checks++;
            if (ReadData !== 32'h0) begin
                $display("FAIL midreset_event c=%0d: got=%h want=%h", c, ReadData, 32'h0);
                errors++;
            end
        end
        DataAdr = A_MASK; #1;
        checks++;
        if (ReadData !== 32'h0) begin
            $display("FAIL midreset_mask: got=%h want=%h", ReadData, 32'h0);
            errors++;
        end
        store(A_MASK, 32'h5);
        store(32'h0000_001C, 32'hA);
        store(32'h0000_0018, 32'hF);
        DataAdr = 32'h0000_0018; #1;
        checks++;
        if (ReadData !== 32'h0) begin
            $display("FAIL outside_read: got=%h want=%h", ReadData, 32'h0);
            errors++;
        end
        DataAdr = A_MASK; #1;
        checks++;
        if (ReadData !== 32'h5) begin
            $display("FAIL outside_store_ignored: got=%h want=%h", ReadData, 32'h5);
            errors++;
        end
    endtask

    task automatic test_random();
        logic [31:0] pick [6];
        pick = '{A_SW, A_KEY, A_EVT, A_MASK, 32'h0000_0018, 32'hFFFF_0020};
        for (int c = 0; c < 800; c++) begin
            rst_n    = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            MemWrite = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
            WriteData = $urandom;
            DataAdr  = pick[$urandom_range(0, 5)] | {30'h0, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
            if ($urandom_range(0, 5) == 0) KEY_n = 4'($urandom);
            tick();
            rst_n = 1'b1;
            MemWrite = 1'b0;
            checks++;
            if (ReadData !== model_read(DataAdr)) begin
                $display("FAIL rand_read c=%0d adr=%h: got=%h want=%h", c, DataAdr, ReadData, model_read(DataAdr));
                errors++;
            end
            checks++;
            if (key_irq !== m_irq) begin
                $display("FAIL rand_irq c=%0d: got=%b want=%b", c, key_irq, m_irq);
                errors++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) hist[i] = 14'h0;
        m_stable = 14'h0; m_event = 4'h0; m_mask = 4'h0; m_irq = 1'b0;
        test_reset();
        test_sw_debounce();
        test_key_glitch();
        test_irq();
        test_w1c_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_input_port.md
# io_input_port

Memory-mapped input peripheral for the RV32I FPGA build: the input counterpart to the LED/seven-segment output path. It performs the following:
- synchronises and debounces the board slide switches and push-buttons;
- detects button presses into sticky event flags;
- presents state and events to the CPU on its data bus;
- raises a level interrupt request.

It sits beside `cpu_top` in the FPGA top level, on the data-bus address/write-data lines.

## Interface
Parameters:
- `N_SW`, 10: number of slide switches.
- `N_KEY`, 4: number of push-buttons (board keys are active-low).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples required to accept a change (10 ms at 50 MHz); minimum 2.
- `BASE_ADDR`, 32'hFFFF_0010: 16-byte-aligned base of the register window.

Ports:
- `clk` input 1: single system clock; all state on rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `SW` input N_SW: raw asynchronous switch levels.
- `KEY_n` input N_KEY: raw asynchronous buttons, 0 = pressed.
- `DataAdr` input 32: CPU data address.
- `WriteData` input 32: CPU store data.
- `MemWrite` input 1: store strobe, one cycle per store.
- `ReadData` output 32: read data for the addressed register, combinational from registered state.
- `key_irq` output 1: registered OR of (KEY_EVENT & IRQ_MASK).

## Operation
- **Window select:** `DataAdr[31:4] == BASE_ADDR[31:4]`. The offset is `DataAdr[3:2]`. Outside the window, `ReadData` = 0 and writes are ignored.
- **Register map:**
  - 0x0 SW_STATE: RO, debounced switches in bits [N_SW-1:0].
  - 0x4 KEY_STATE: RO, debounced keys, inverted so 1 = pressed.
  - 0x8 KEY_EVENT: sticky press flags, write-1-to-clear.
  - 0xC IRQ_MASK: RW, bits [N_KEY-1:0].
  - Unused bits read 0. Writes to RO offsets are ignored.
- **Per input bit:**
  - Two-flop synchroniser.
  - Debounce counter: while sync output ≠ stable value, increment. When it reaches DEBOUNCE_CYCLES-1 on a mismatching sample, update the stable value and clear the counter. Any matching sample clears the counter; a glitch restarts the count.
- **Press detection:** a key's debounced stable value changing 0→1 sets KEY_EVENT[i] on the same edge. Release does not set a flag.
- **Simultaneous set and W1C on the same bit:** set wins (bit stays 1). W1C on other bits proceeds normally.
- **Reset:** applied on a `clk` edge with `rst_n`=0.
  - All synchronisers, counters, stable values, KEY_EVENT, IRQ_MASK and `key_irq` go to 0.
  - `ReadData` is then 0 at every offset.
  - Reset mid-debounce discards the partial count.
  - A key held through reset is accepted as a new press DEBOUNCE_CYCLES+2 cycles after reset release.

## Timing
- **Input latency:** raw change settling before edge k → sync1 at k, sync2 at k+1, stable value and KEY_EVENT updated at edge k+1+DEBOUNCE_CYCLES.
- **`ReadData`:** zero-latency from DataAdr (single-cycle CPU load). It reflects register values as of the last edge.
- **Stores:** a W1C or IRQ_MASK store takes effect at the edge where MemWrite=1. A subsequent read in the next cycle sees the new value.
- **`key_irq`:** asserts one cycle after KEY_EVENT & IRQ_MASK becomes nonzero. It deasserts one cycle after the clearing write or the mask write.

## Structure
- Package `io_pkg`:
  - register offset constants `IO_SW_STATE`, `IO_KEY_STATE`, `IO_KEY_EVENT`, `IO_IRQ_MASK`;
  - the default `BASE_ADDR`;
  - the debounce-count width function (`$clog2(DEBOUNCE_CYCLES)`).
- Sub-module `debounce_bit`:
  - one synchroniser plus counter plus stable register;
  - outputs `stable` and a one-cycle `rise` pulse;
  - instantiated N_SW+N_KEY times via generate.

## Test plan
Run with DEBOUNCE_CYCLES=4, N_SW=10, N_KEY=4, BASE_ADDR=32'hFFFF_0010.
1. Reset, then read 0x10, 0x14, 0x18, 0x1C → all 0; `key_irq`=0.
2. Drive SW=10'h2A5 at edge k → SW_STATE reads 0x2A5 from edge k+5, and is still 0 at edge k+4.
3. KEY_n[1] low for 3 cycles, then high → no KEY_STATE or KEY_EVENT change. Held low for 6 cycles → KEY_STATE=0x2 and KEY_EVENT=0x2 at edge k+5.
4. IRQ_MASK=0x2 with KEY_EVENT[1]=1 → `key_irq`=1. Store 0x2 to 0x18 → KEY_EVENT=0 and `key_irq`=0 one cycle later.
5. W1C 0xF to 0x18 on the same edge KEY_EVENT[0] is set → KEY_EVENT reads 0x1.
6. `rst_n`=0 for one edge midway through a key debounce, and a store to 32'h0000_0018 → no event; the unrelated-address store is ignored and `ReadData`=0 for that address.
